sipo_deser: RTL and testbench

- Serial-to-parallel deserializer sitting directly downstream of the dff stage; consumes its registered d_out bit stream one bit per qualified clock.
- Packs WIDTH bits into a word and presents it on a valid/ready handshake to the next consumer.
- Double-buffered: shift register keeps collecting while a completed word waits in the output register. Sticky overflow flag on loss.

---
 rtl/sipo_deser_if.sv | 25 ++
 rtl/sipo_deser.sv | 117 +++++++++++
 tb/tb_sipo_deser.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_deser_if.sv
// Serial-in / word-out bundle for sipo_deser: bit stream in, word handshake out.
interface sipo_deser_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             bit_in;
    logic             bit_valid;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_count;
    logic             overflow;
    logic             parity_err;

    modport master (
        output bit_in, bit_valid, word_ready,
        input  word_out, word_valid, bit_count, overflow, parity_err
    );

    modport slave (
        input  bit_in, bit_valid, word_ready,
        output word_out, word_valid, bit_count, overflow, parity_err
    );
endinterface

// File: rtl/sipo_deser.sv
// Double-buffered serial-to-parallel deserializer with sticky overflow.
// Define SIPO_PARITY_EN to expect an even-parity beat after each word.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic         clk,
    input logic         rst,
    sipo_deser_if.slave io
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
`ifdef SIPO_PARITY_EN
        PARITY,
`endif
        SHIFT
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q;
    logic             ovf_q;
    logic             last_bit;
    logic             done;
    logic             load;
    logic             drop;
    logic             consume;
`ifdef SIPO_PARITY_EN
    logic             perr_q, perr_d;
`endif

    always_comb begin
        if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], io.bit_in};
        else           shift_d = {io.bit_in, shift_q[WIDTH-1:1]};
        last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
`ifdef SIPO_PARITY_EN
        // Word is complete only once its parity beat arrives.
        done   = io.bit_valid && (state_q == PARITY);
        word_d = shift_q;
        perr_d = (^shift_q) != io.bit_in;
`else
        done   = io.bit_valid && last_bit;
        word_d = shift_d;
`endif
        load    = done && (!valid_q || io.word_ready);
        drop    = done && valid_q && !io.word_ready;
        consume = !done && valid_q && io.word_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            if (io.bit_valid) begin
                unique case (state_q)
                    IDLE: begin
                        shift_q <= shift_d;
                        cnt_q   <= CW'(1);
                        state_q <= SHIFT;
                    end
                    SHIFT: begin
                        shift_q <= shift_d;
                        if (last_bit) begin
                            cnt_q   <= '0;
`ifdef SIPO_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= IDLE;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PARITY: state_q <= IDLE;
`endif
                    default: state_q <= IDLE;
                endcase
            end

            unique case (1'b1)
                load: begin
                    word_q  <= word_d;
                    valid_q <= 1'b1;
`ifdef SIPO_PARITY_EN
                    perr_q  <= perr_d;
`endif
                end
                drop:    ovf_q   <= 1'b1;
                consume: valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign io.word_out   = word_q;
    assign io.word_valid = valid_q;
    assign io.bit_count  = cnt_q;
    assign io.overflow   = ovf_q;
`ifdef SIPO_PARITY_EN
    assign io.parity_err = perr_q & valid_q;
`else
    assign io.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: per-cycle model compare plus literal checks.
module tb_sipo_deser;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
`ifdef SIPO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(W)) io ();

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
        .clk(clk),
        .rst(rst),
        .io (io.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: bits land at their arrival index; word completes on the
    // W-th data bit (or the following parity beat when enabled).
    int           m_cnt;
    logic [W-1:0] m_acc, m_word, acc_n, word_e;
    logic         m_par, m_valid, m_ovf, m_pe, done_e, pe_e;
    logic         started = 1'b0;

    assign acc_n  = (m_cnt == 0 ? '0 : m_acc)
                  | ({{(W-1){1'b0}}, io.bit_in} << m_cnt);
    assign done_e = io.bit_valid && (PAR ? m_par : (m_cnt == W - 1));
    assign word_e = PAR ? m_acc : acc_n;
    assign pe_e   = PAR && ((($countones(m_acc) % 2) == 1) != io.bit_in);

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_cnt <= 0; m_acc <= '0; m_par <= 1'b0;
            m_word <= '0; m_valid <= 1'b0; m_ovf <= 1'b0; m_pe <= 1'b0;
        end else begin
            if (io.bit_valid) begin
                if (PAR && m_par) begin
                    m_par <= 1'b0;
                end else if (m_cnt == W - 1) begin
                    m_cnt <= 0;
                    m_acc <= acc_n;
                    if (PAR) m_par <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                    m_acc <= acc_n;
                end
            end
            if (done_e) begin
                if (!m_valid || io.word_ready) begin
                    m_word  <= word_e;
                    m_valid <= 1'b1;
                    m_pe    <= pe_e;
                end else begin
                    m_ovf <= 1'b1;
                end
            end else if (m_valid && io.word_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_valid", io.word_valid, m_valid);
            check("m_count", io.bit_count, m_cnt);
            check("m_ovf", io.overflow, m_ovf);
            check("m_perr", io.parity_err, m_valid & m_pe);
            if (m_valid) check("m_word", io.word_out, m_word);
        end
    end

    task automatic beat(input logic b, input logic v, input logic r);
        io.bit_in     = b;
        io.bit_valid  = v;
        io.word_ready = r;
        @(negedge clk);
    endtask

    // rb: ready on body beats, rl: ready on the completing beat.
    task automatic send_word(input logic [W-1:0] w, input bit gaps,
                             input logic rb, input logic rl,
                             input logic pflip);
        for (int i = 0; i < W; i++) begin
            int ng;
            ng = gaps ? 1 + (i % 3) : 0;
            for (int g = 0; g < ng; g++) beat(1'b0, 1'b0, rb);
            beat(w[i], 1'b1, (i == W - 1 && !PAR) ? rl : rb);
        end
        if (PAR) beat((^w) ^ pflip, 1'b1, rl);
    endtask

    initial begin
        io.bit_in = 1'b0; io.bit_valid = 1'b0; io.word_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++)
            beat(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        rst = 1'b1;
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        check("rst_word", io.word_out, 0);
        check("rst_valid", io.word_valid, 0);
        check("rst_count", io.bit_count, 0);
        check("rst_ovf", io.overflow, 0);
        rst = 1'b0;

        send_word(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        check("a5_valid", io.word_valid, 1);
        check("a5_word", io.word_out, 8'hA5);
        beat(1'b0, 1'b0, 1'b1);
        check("a5_once", io.word_valid, 0);

        send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        check("3c_word", io.word_out, 8'h3C);
        check("3c_valid", io.word_valid, 1);
        beat(1'b0, 1'b0, 1'b1);
        check("3c_taken", io.word_valid, 0);

        send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ov_word", io.word_out, 8'h11);
        check("ov_valid", io.word_valid, 1);
        check("ov_flag", io.overflow, 1);
        beat(1'b0, 1'b0, 1'b1);
        check("ov_taken", io.word_valid, 0);
        check("ov_sticky", io.overflow, 1);

        rst = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("ov_clr", io.overflow, 0);

        send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rep_word", io.word_out, 8'h22);
        check("rep_valid", io.word_valid, 1);
        check("rep_ovf", io.overflow, 0);
        beat(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) beat(1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        check("gap_hold", io.bit_count, 5);
        rst = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("mid_rst", io.bit_count, 0);
        send_word(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ff_word", io.word_out, 8'hFF);
        check("ff_perr", io.parity_err, 0);
        beat(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
        send_word(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        check("par_word", io.word_out, 8'hA5);
        check("par_err", io.parity_err, 1);
        beat(1'b0, 1'b0, 1'b1);
`endif

        beat(1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
